align_sequencer: RTL and testbench

ALIGN_SEQUENCER -- requirements
Module: align_sequencer

---
 rtl/align_sequencer_pkg.sv | 12 +
 rtl/align_sequencer_if.sv | 17 +
 rtl/align_sym_fetch.sv | 61 ++++++
 rtl/align_sequencer.sv | 125 ++++++++++++
 tb/tb_align_sequencer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/align_sequencer_pkg.sv
// Shared constants and state encoding for the alignment sequencer and the systolic array.
package align_sequencer_pkg;
  localparam int N           = 8;
  localparam int BP_WIDTH    = 2;
  localparam int CALC_WIDTH  = 16;
  localparam int SEQ_MAX_LEN = 256;
  localparam int LEN_WIDTH   = 12;

  typedef enum logic [2:0] {
    IDLE, NEWSEQ, LOAD_S, UPDATE, GAP, STREAM_T, WAIT, FIN
  } seq_state_e;
endpackage

// File: rtl/align_sequencer_if.sv
// Sequencer-to-systolic-array link: S loading, T streaming and array status.
interface align_sequencer_if #(
  parameter int BP_WIDTH   = align_sequencer_pkg::BP_WIDTH,
  parameter int CALC_WIDTH = align_sequencer_pkg::CALC_WIDTH
);
  logic                  new_seq;
  logic [BP_WIDTH-1:0]   S;
  logic                  s_update;
  logic                  ack;
  logic [BP_WIDTH-1:0]   T;
  logic                  valid;
  logic                  array_busy;
  logic [CALC_WIDTH-1:0] max_i;

  modport master (output new_seq, S, s_update, ack, T, valid, input array_busy, max_i);
  modport slave  (input new_seq, S, s_update, ack, T, valid, output array_busy, max_i);
endinterface

// File: rtl/align_sym_fetch.sv
// Buffer address generation for S (descending per tile) and T (ascending), with
// 1-cycle read alignment and PAD_BP substitution past the sequence end.
module align_sym_fetch #(
  parameter int N           = align_sequencer_pkg::N,
  parameter int BP_WIDTH    = align_sequencer_pkg::BP_WIDTH,
  parameter int SEQ_MAX_LEN = align_sequencer_pkg::SEQ_MAX_LEN,
  parameter int LEN_WIDTH   = align_sequencer_pkg::LEN_WIDTH,
  parameter logic [BP_WIDTH-1:0] PAD_BP = '0,
  localparam int AW = $clog2(SEQ_MAX_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_req,
  input  logic                 s_first,
  input  logic [LEN_WIDTH-1:0] s_base,
  input  logic [LEN_WIDTH-1:0] s_len,
  input  logic                 t_req,
  input  logic                 t_first,
  input  logic [LEN_WIDTH-1:0] t_len,
  output logic [AW-1:0]        s_addr,
  output logic [AW-1:0]        t_addr,
  input  logic [BP_WIDTH-1:0]  s_rdata,
  input  logic [BP_WIDTH-1:0]  t_rdata,
  output logic [BP_WIDTH-1:0]  s_sym,
  output logic [BP_WIDTH-1:0]  t_sym
);
  logic [LEN_WIDTH-1:0] s_idx, t_idx, s_nxt_p1, t_nxt_p1;
  logic                 s_vld_p1, t_vld_p1, s_pad_p1, t_pad_p1;

  function automatic logic [BP_WIDTH-1:0] pad_sym(input logic vld, input logic pad,
                                                  input logic [BP_WIDTH-1:0] d);
    if (!vld) return '0;
    if (pad)  return PAD_BP;
    return d;
  endfunction

  always_comb begin
    s_idx  = s_first ? s_base + LEN_WIDTH'(N - 1) : s_nxt_p1;
    t_idx  = t_first ? '0 : t_nxt_p1;
    s_addr = s_req ? s_idx[AW-1:0] : '0;
    t_addr = t_req ? t_idx[AW-1:0] : '0;
  end

  // Stage p1: buffer data returns; pad/valid flags travel alongside it
  always_ff @(posedge clk) begin
    if (s_req) s_nxt_p1 <= s_idx - LEN_WIDTH'(1);
    if (t_req) t_nxt_p1 <= t_idx + LEN_WIDTH'(1);
    s_pad_p1 <= (s_idx >= s_len);
    t_pad_p1 <= (t_idx >= t_len);
    if (rst) begin
      s_vld_p1 <= 1'b0;
      t_vld_p1 <= 1'b0;
    end else begin
      s_vld_p1 <= s_req;
      t_vld_p1 <= t_req;
    end
  end

  assign s_sym = pad_sym(s_vld_p1, s_pad_p1, s_rdata);
  assign t_sym = pad_sym(t_vld_p1, t_pad_p1, t_rdata);
endmodule

// File: rtl/align_sequencer.sv
// Job sequencer for the systolic aligner: tiles S into N-base chunks, streams T per
// tile and keeps the running maximum of the per-tile scores.
module align_sequencer #(
  parameter int N           = align_sequencer_pkg::N,
  parameter int BP_WIDTH    = align_sequencer_pkg::BP_WIDTH,
  parameter int CALC_WIDTH  = align_sequencer_pkg::CALC_WIDTH,
  parameter int SEQ_MAX_LEN = align_sequencer_pkg::SEQ_MAX_LEN,
  parameter int LEN_WIDTH   = align_sequencer_pkg::LEN_WIDTH,
  parameter logic [BP_WIDTH-1:0] PAD_BP = '0,
  localparam int AW = $clog2(SEQ_MAX_LEN)
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  s_len,
  input  logic [LEN_WIDTH-1:0]  t_len,
  output logic [AW-1:0]         s_addr,
  input  logic [BP_WIDTH-1:0]   s_rdata,
  output logic [AW-1:0]         t_addr,
  input  logic [BP_WIDTH-1:0]   t_rdata,
  align_sequencer_if.master     arr,
  output logic                  busy_o,
  output logic                  done,
  output logic                  err,
  output logic [CALC_WIDTH-1:0] score
);
  import align_sequencer_pkg::*;

  seq_state_e           state_q, state_d;
  logic [LEN_WIDTH-1:0] s_len_q, t_len_q, tile_q, cnt_q, tile_nxt, next_base, s_base;
  logic                 wait_exit, more_tiles, len_zero, len_over;
  logic                 s_req, s_first, t_req, t_first;
  logic [BP_WIDTH-1:0]  s_sym, t_sym;

  function automatic logic [CALC_WIDTH-1:0] umax(input logic [CALC_WIDTH-1:0] a,
                                                 input logic [CALC_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    tile_nxt   = tile_q + LEN_WIDTH'(1);
    next_base  = LEN_WIDTH'(tile_nxt * N);
    more_tiles = (next_base < s_len_q);
    // The first WAIT cycle still sees the array's busy from before it picked up the tile
    wait_exit  = (state_q == WAIT) && (cnt_q != '0) && !arr.array_busy;
    len_zero   = (s_len == '0) || (t_len == '0);
    len_over   = (s_len > LEN_WIDTH'(SEQ_MAX_LEN)) || (t_len > LEN_WIDTH'(SEQ_MAX_LEN));
    s_req      = (state_q == NEWSEQ) || ((state_q == LOAD_S) && (cnt_q != LEN_WIDTH'(N - 1)))
                 || (wait_exit && more_tiles);
    s_first    = (state_q != LOAD_S);
    s_base     = (state_q == WAIT) ? next_base : '0;
    t_req      = (state_q == GAP) || ((state_q == STREAM_T) && (cnt_q != t_len_q - LEN_WIDTH'(1)));
    t_first    = (state_q == GAP);
  end

  always_ff @(posedge clk) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = (len_zero || len_over) ? FIN : NEWSEQ;
      NEWSEQ:   state_d = LOAD_S;
      LOAD_S:   if (cnt_q == LEN_WIDTH'(N - 1)) state_d = UPDATE;
      UPDATE:   state_d = GAP;
      GAP:      state_d = STREAM_T;
      STREAM_T: if (cnt_q == t_len_q - LEN_WIDTH'(1)) state_d = WAIT;
      WAIT:     if (wait_exit) state_d = more_tiles ? LOAD_S : FIN;
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    arr.new_seq  = (state_q == NEWSEQ);
    arr.s_update = (state_q == UPDATE);
    arr.valid    = (state_q == STREAM_T);
    arr.ack      = (state_q == LOAD_S) || (state_q == GAP) || (state_q == STREAM_T) || (state_q == WAIT);
    arr.S        = s_sym;
    arr.T        = t_sym;
    done         = (state_q == FIN);
    busy_o       = (state_q != IDLE);
  end

  // Per-state cycle counter; saturates at 1 in WAIT so long busy periods never wrap it
  always_ff @(posedge clk) begin
    if (reset_i || state_d != state_q || state_q == IDLE) cnt_q <= '0;
    else if (state_q == WAIT)                             cnt_q <= LEN_WIDTH'(1);
    else                                                  cnt_q <= cnt_q + LEN_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      s_len_q <= '0;
      t_len_q <= '0;
      tile_q  <= '0;
      score   <= '0;
      err     <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        s_len_q <= s_len;
        t_len_q <= t_len;
        tile_q  <= '0;
        score   <= '0;
        err     <= !len_zero && len_over;
      end
      if (wait_exit) begin
        tile_q <= tile_nxt;
        score  <= umax(score, arr.max_i);
      end
    end
  end

  align_sym_fetch #(
    .N(N), .BP_WIDTH(BP_WIDTH), .SEQ_MAX_LEN(SEQ_MAX_LEN), .LEN_WIDTH(LEN_WIDTH), .PAD_BP(PAD_BP)
  ) u_fetch (
    .clk(clk), .rst(reset_i),
    .s_req(s_req), .s_first(s_first), .s_base(s_base), .s_len(s_len_q),
    .t_req(t_req), .t_first(t_first), .t_len(t_len_q),
    .s_addr(s_addr), .t_addr(t_addr), .s_rdata(s_rdata), .t_rdata(t_rdata),
    .s_sym(s_sym), .t_sym(t_sym)
  );
endmodule

// File: tb/tb_align_sequencer.sv
// Randomized bench: a job-level model expands each job into its expected per-cycle trace.
module tb_align_sequencer;
  import align_sequencer_pkg::*;

  localparam logic [1:0] PAD = 2'd3;

  logic                  clk = 1'b0;
  logic                  reset_i, start, busy_o, done, err;
  logic [LEN_WIDTH-1:0]  s_len, t_len;
  logic [7:0]            s_addr, t_addr;
  logic [1:0]            s_rdata, t_rdata;
  logic [CALC_WIDTH-1:0] score;
  logic [1:0]            s_mem [SEQ_MAX_LEN];
  logic [1:0]            t_mem [SEQ_MAX_LEN];

  align_sequencer_if arr ();

  align_sequencer #(.PAD_BP(PAD)) dut (
    .clk(clk), .reset_i(reset_i), .start(start), .s_len(s_len), .t_len(t_len),
    .s_addr(s_addr), .s_rdata(s_rdata), .t_addr(t_addr), .t_rdata(t_rdata),
    .arr(arr), .busy_o(busy_o), .done(done), .err(err), .score(score)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    s_rdata <= s_mem[s_addr];
    t_rdata <= t_mem[t_addr];
  end

  // ctl = {new_seq, s_update, valid, done, ack, busy_o}
  typedef struct {
    logic [5:0]  ctl;
    bit          s_chk;
    logic [1:0]  s_exp;
    logic [1:0]  t_exp;
    bit          busy_in;
    logic [15:0] max_in;
  } cyc_t;

  cyc_t tr[$];
  int   tile_max[$];
  int   exp_score;
  bit   exp_err;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] ctl_now();
    return {arr.new_seq, arr.s_update, arr.valid, done, arr.ack, busy_o};
  endfunction

  function automatic cyc_t mk(input logic [5:0] ctl);
    cyc_t c;
    c.ctl = ctl; c.s_chk = 1'b0; c.s_exp = '0; c.t_exp = '0;
    c.busy_in = 1'($urandom_range(0, 1));
    c.max_in  = 16'($urandom);
    return c;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < SEQ_MAX_LEN; i++) begin
      s_mem[i] = 2'($urandom);
      t_mem[i] = 2'($urandom);
    end
  endtask

  // Job-level reference: expected cycle sequence derived from the tiling rules
  task automatic build(input int sl, input int tl);
    cyc_t c;
    int   nt, m, d, idx;
    tr.delete();
    exp_score = 0;
    exp_err   = 1'b0;
    if (sl == 0 || tl == 0) begin
      tr.push_back(mk(6'b000101));
    end else if (sl > SEQ_MAX_LEN || tl > SEQ_MAX_LEN) begin
      exp_err = 1'b1;
      tr.push_back(mk(6'b000101));
    end else begin
      tr.push_back(mk(6'b100001));
      nt = (sl + N - 1) / N;
      for (int t = 0; t < nt; t++) begin
        for (int k = 0; k < N; k++) begin
          idx = t * N + N - 1 - k;
          c = mk(6'b000011);
          c.s_chk = 1'b1;
          c.s_exp = (idx < sl) ? s_mem[idx] : PAD;
          tr.push_back(c);
        end
        tr.push_back(mk(6'b010001));
        tr.push_back(mk(6'b000011));
        for (int k = 0; k < tl; k++) begin
          c = mk(6'b001011);
          c.t_exp = t_mem[k];
          tr.push_back(c);
        end
        m = (t < tile_max.size()) ? tile_max[t] : int'($urandom_range(0, 65535));
        if (m > exp_score) exp_score = m;
        d = $urandom_range(0, 3);
        for (int w = 0; w < d + 2; w++) begin
          c = mk(6'b000011);
          c.max_in = 16'(m);
          if (w == 0)      c.busy_in = 1'($urandom_range(0, 1));
          else if (w <= d) c.busy_in = 1'b1;
          else             c.busy_in = 1'b0;
          tr.push_back(c);
        end
      end
      tr.push_back(mk(6'b000101));
    end
    tr.push_back(mk(6'b000000));
  endtask

  task automatic run_job(input int sl, input int tl, input int abort_at, input bit pokes);
    build(sl, tl);
    @(negedge clk);
    start = 1'b1;
    s_len = LEN_WIDTH'(sl);
    t_len = LEN_WIDTH'(tl);
    for (int k = 0; k < tr.size(); k++) begin
      @(negedge clk);
      start = 1'b0;
      s_len = LEN_WIDTH'($urandom_range(0, 40));
      t_len = LEN_WIDTH'($urandom_range(0, 40));
      if (pokes && k < tr.size() - 1 && (k == 2 || $urandom_range(0, 3) == 0)) start = 1'b1;
      arr.array_busy = tr[k].busy_in;
      arr.max_i      = tr[k].max_in;
      #1;
      chk("ctl", 32'(ctl_now()), 32'(tr[k].ctl));
      if (tr[k].s_chk)  chk("S", 32'(arr.S), 32'(tr[k].s_exp));
      if (tr[k].ctl[3]) chk("T", 32'(arr.T), 32'(tr[k].t_exp));
      if (tr[k].ctl[2]) begin
        chk("err", 32'(err), 32'(exp_err));
        if (!exp_err) chk("score", 32'(score), 32'(exp_score));
      end
      if (k == abort_at) begin
        start   = 1'b0;
        reset_i = 1'b1;
        @(negedge clk); #1;
        chk("rst_ctl", 32'(ctl_now()), 32'(0));
        chk("rst_sym", 32'({arr.S, arr.T}), 32'(0));
        chk("rst_score", 32'(score), 32'(0));
        reset_i = 1'b0;
        repeat (3) begin
          @(negedge clk); #1;
          chk("post_rst_ctl", 32'(ctl_now()), 32'(0));
        end
        break;
      end
    end
    tile_max.delete();
  endtask

  initial begin
    reset_i = 1'b1; start = 1'b0; s_len = '0; t_len = '0;
    arr.array_busy = 1'b0; arr.max_i = '0;
    fill_mem();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctl", 32'(ctl_now()), 32'(0));
    chk("reset_sym", 32'({arr.S, arr.T}), 32'(0));
    chk("reset_addr", 32'({s_addr, t_addr}), 32'(0));
    chk("reset_score", 32'(score), 32'(0));
    chk("reset_err", 32'(err), 32'(0));
    reset_i = 1'b0;

    run_job(8, 5, -1, 1'b0);
    tile_max = '{7, 12, 9};
    run_job(17, 6, -1, 1'b1);
    chk("score_12", 32'(score), 32'(12));
    run_job(0, 4, -1, 1'b0);
    run_job(5, 0, -1, 1'b1);
    run_job(300, 4, -1, 1'b0);
    run_job(6, 300, -1, 1'b1);
    run_job(8, 5, -1, 1'b0);
    run_job(12, 7, 13, 1'b0);
    run_job(9, 3, -1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      fill_mem();
      run_job($urandom_range(1, 40), $urandom_range(1, 12), -1, 1'b1);
    end
    fill_mem();
    run_job(256, 2, -1, 1'b1);
    run_job(3, 256, -1, 1'b1);
    run_job(N, 1, -1, 1'b0);
    run_job(1, 1, -1, 1'b1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
